// File: rtl/vga_fb_source_if.sv
// Pixel-write, clear-control and status signals between a drawing agent
// (master) and the frame-buffer pixel source (slave).
interface vga_fb_source_if;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_x;
   logic [6:0]  wr_y;
   logic [11:0] wr_data;
   logic        clear_req;
   logic [11:0] clear_color;
   logic        busy;
   logic        oob;

   modport master (
      output wr_valid, wr_x, wr_y, wr_data, clear_req, clear_color,
      input  wr_ready, busy, oob
   );

   modport slave (
      input  wr_valid, wr_x, wr_y, wr_data, clear_req, clear_color,
      output wr_ready, busy, oob
   );
endinterface

// File: rtl/vga_fb_source.sv
// 160x120x12 frame buffer feeding the VGA controller with 4x upscaling; the
// single RAM port is shared by display reads, pixel writes and a clear engine.
module vga_fb_source #(
   parameter int FB_W     = 160,
   parameter int FB_H     = 120,
   parameter int FB_DEPTH = 19200
) (
   input  logic        vga_clk,
   input  logic        clrn,
   input  logic [8:0]  row_addr,
   input  logic [9:0]  col_addr,
   input  logic        rdn,
   output logic [11:0] d_out,
   vga_fb_source_if.slave host
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [7:0]  W_LIM     = 8'(FB_W);
   localparam logic [6:0]  H_LIM     = 7'(FB_H);
   localparam logic [14:0] LAST_ADDR = 15'(FB_DEPTH - 1);

   state_t      r_state, w_nextState;
   logic [14:0] r_clrAddr;
   logic [11:0] r_clrColor;
   logic        r_oob;
   logic        r_rdnQ;
   logic        r_slotQ;
   logic [11:0] r_pixQ;
   logic [11:0] r_ramRd;
   logic [11:0] r_mem [FB_DEPTH];

   logic        w_readSlot;
   logic        w_inRange;
   logic [14:0] w_dispAddr;
   logic [14:0] w_wrAddr;
   logic        w_wrReady;
   logic        w_ramWe;
   logic [14:0] w_ramAddr;
   logic [11:0] w_ramWdata;
   logic        w_clrStart;
   logic        w_clrStep;
   logic        w_oobNext;
   logic        w_unusedBits;

   // y*160 + x built from two shifts and an add so no multiplier is inferred
   function automatic logic [14:0] fbAddr(input logic [7:0] x, input logic [6:0] y);
      return ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
   endfunction

   assign w_readSlot   = !rdn && (col_addr[1:0] == 2'b00);
   assign w_dispAddr   = fbAddr(col_addr[9:2], row_addr[8:2]);
   assign w_wrAddr     = fbAddr(host.wr_x, host.wr_y);
   assign w_inRange    = (host.wr_x < W_LIM) && (host.wr_y < H_LIM);
   assign w_unusedBits = &{1'b0, row_addr[1:0]};

   // Port arbitration: the display read slot always owns the RAM; clear_req
   // takes priority over a pending write in the cycle it arrives
   always_comb begin
      w_nextState = r_state;
      w_wrReady   = 1'b0;
      w_ramWe     = 1'b0;
      w_ramAddr   = w_dispAddr;
      w_ramWdata  = host.wr_data;
      w_clrStart  = 1'b0;
      w_clrStep   = 1'b0;
      w_oobNext   = 1'b0;
      case (r_state)
         IDLE: begin
            if (host.clear_req) begin
               w_clrStart  = 1'b1;
               w_nextState = CLEAR;
            end else begin
               w_wrReady = clrn && !w_readSlot;
               if (host.wr_valid && w_wrReady) begin
                  if (w_inRange) begin
                     w_ramWe   = 1'b1;
                     w_ramAddr = w_wrAddr;
                  end else begin
                     w_oobNext = 1'b1;
                  end
               end
            end
         end
         CLEAR: begin
            if (!w_readSlot) begin
               w_ramWe    = 1'b1;
               w_ramAddr  = r_clrAddr;
               w_ramWdata = r_clrColor;
               w_clrStep  = 1'b1;
               if (r_clrAddr == LAST_ADDR) w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         r_state    <= IDLE;
         r_clrAddr  <= '0;
         r_clrColor <= '0;
         r_oob      <= 1'b0;
         r_rdnQ     <= 1'b1;
         r_slotQ    <= 1'b0;
         r_pixQ     <= '0;
      end else begin
         r_state <= w_nextState;
         r_oob   <= w_oobNext;
         r_rdnQ  <= rdn;
         r_slotQ <= w_readSlot;
         if (r_slotQ) r_pixQ <= r_ramRd;
         if (w_clrStart) begin
            r_clrColor <= host.clear_color;
            r_clrAddr  <= '0;
         end else if (w_clrStep) begin
            r_clrAddr <= (r_clrAddr == LAST_ADDR) ? '0 : r_clrAddr + 15'd1;
         end
      end
   end

   // Single-port RAM with registered read; contents are deliberately not reset
   always_ff @(posedge vga_clk) begin
      if (w_ramWe) r_mem[w_ramAddr] <= w_ramWdata;
      r_ramRd <= r_mem[w_ramAddr];
   end

   assign d_out         = r_rdnQ ? 12'h000 : r_pixQ;
   assign host.wr_ready = w_wrReady;
   assign host.busy     = (r_state == CLEAR);
   assign host.oob      = r_oob;

endmodule
